// File: rtl/cdb_arbiter_if.sv
// FU completion handshake and common-data-bus broadcast signals for cdb_arbiter.
interface cdb_arbiter_if #(
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BR_IDX_W  = 3
);
    logic                          flush;
    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU*TAG_W-1:0]       fu_tag;
    logic [NUM_FU*DATA_W-1:0]      fu_result;
    logic [NUM_FU-1:0]             fu_br;
    logic [NUM_FU*BR_IDX_W-1:0]    fu_br_idx;
    logic [NUM_FU-1:0]             fu_take_branch;
    logic [NUM_FU-1:0]             fu_ready;
    logic [NUM_LANES-1:0]          cdb_en;
    logic [NUM_LANES*TAG_W-1:0]    cdb_tag;
    logic [NUM_LANES*DATA_W-1:0]   cdb_result;
    logic                          cdb_br_valid;
    logic [BR_IDX_W-1:0]           cdb_br_idx;
    logic                          cdb_take_branch;
    logic [DATA_W-1:0]             cdb_br_target;

    modport master (
        output flush, fu_valid, fu_tag, fu_result, fu_br, fu_br_idx, fu_take_branch,
        input  fu_ready, cdb_en, cdb_tag, cdb_result,
               cdb_br_valid, cdb_br_idx, cdb_take_branch, cdb_br_target
    );

    modport slave (
        input  flush, fu_valid, fu_tag, fu_result, fu_br, fu_br_idx, fu_take_branch,
        output fu_ready, cdb_en, cdb_tag, cdb_result,
               cdb_br_valid, cdb_br_idx, cdb_take_branch, cdb_br_target
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffers one completion per functional unit and grants CDB lanes with rotating
// priority; at most one branch resolves on the bus per cycle.
module cdb_arbiter #(
    parameter int unsigned NUM_FU    = 4,
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned TAG_W     = 6,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BR_IDX_W  = 3
) (
    input logic         clock,
    input logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [TAG_W-1:0]    tag;
        logic [DATA_W-1:0]   result;
        logic                br;
        logic [BR_IDX_W-1:0] br_idx;
        logic                take;
    } entry_t;

    entry_t            slot_q [NUM_FU];
    logic [NUM_FU-1:0] slot_valid_q;
    logic [PTR_W-1:0]  rr_ptr_q;

    logic [NUM_FU-1:0]    grant;
    logic [NUM_LANES-1:0] lane_en;
    logic [PTR_W-1:0]     lane_sel [NUM_LANES];
    logic                 br_grant;
    logic [PTR_W-1:0]     br_sel;
    logic [PTR_W-1:0]     rr_ptr_next;
    logic [PTR_W-1:0]     scan_idx;
    int                   used;

    // Rotating scan from rr_ptr; a second branch in scan order is skipped so
    // the single branch-resolution port is never oversubscribed.
    always_comb begin
        grant       = '0;
        lane_en     = '0;
        br_grant    = 1'b0;
        br_sel      = '0;
        rr_ptr_next = rr_ptr_q;
        scan_idx    = '0;
        used        = 0;
        for (int l = 0; l < int'(NUM_LANES); l++) lane_sel[l] = '0;
        for (int k = 0; k < int'(NUM_FU); k++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + k) % int'(NUM_FU));
            if (slot_valid_q[scan_idx] && (used < int'(NUM_LANES)) &&
                !(slot_q[scan_idx].br && br_grant)) begin
                grant[scan_idx] = 1'b1;
                for (int l = 0; l < int'(NUM_LANES); l++) begin
                    if (l == used) begin
                        lane_en[l]  = 1'b1;
                        lane_sel[l] = scan_idx;
                    end
                end
                if (slot_q[scan_idx].br) begin
                    br_grant = 1'b1;
                    br_sel   = scan_idx;
                end
                rr_ptr_next = PTR_W'((int'(scan_idx) + 1) % int'(NUM_FU));
                used        = used + 1;
            end
        end
    end

    // A slot that is being broadcast this cycle can take a new entry without a bubble.
    always_comb begin
        bus.fu_ready = '0;
        for (int i = 0; i < int'(NUM_FU); i++)
            bus.fu_ready[i] = !bus.flush && (!slot_valid_q[i] || grant[i]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            slot_valid_q        <= '0;
            rr_ptr_q            <= '0;
            for (int i = 0; i < int'(NUM_FU); i++) slot_q[i] <= '0;
            bus.cdb_en          <= '0;
            bus.cdb_tag         <= '0;
            bus.cdb_result      <= '0;
            bus.cdb_br_valid    <= 1'b0;
            bus.cdb_br_idx      <= '0;
            bus.cdb_take_branch <= 1'b0;
            bus.cdb_br_target   <= '0;
        end else if (bus.flush) begin
            // Squash: pending completions are dropped, rotation state survives.
            slot_valid_q        <= '0;
            bus.cdb_en          <= '0;
            bus.cdb_tag         <= '0;
            bus.cdb_result      <= '0;
            bus.cdb_br_valid    <= 1'b0;
            bus.cdb_br_idx      <= '0;
            bus.cdb_take_branch <= 1'b0;
            bus.cdb_br_target   <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_next;
            for (int l = 0; l < int'(NUM_LANES); l++) begin
                bus.cdb_en[l] <= lane_en[l];
                bus.cdb_tag[l*TAG_W +: TAG_W] <=
                    lane_en[l] ? slot_q[lane_sel[l]].tag : TAG_W'(0);
                bus.cdb_result[l*DATA_W +: DATA_W] <=
                    lane_en[l] ? slot_q[lane_sel[l]].result : DATA_W'(0);
            end
            bus.cdb_br_valid    <= br_grant;
            bus.cdb_br_idx      <= br_grant ? slot_q[br_sel].br_idx : BR_IDX_W'(0);
            bus.cdb_take_branch <= br_grant && slot_q[br_sel].take;
            bus.cdb_br_target   <= br_grant ? slot_q[br_sel].result : DATA_W'(0);
            for (int i = 0; i < int'(NUM_FU); i++) begin
                if (bus.fu_valid[i] && bus.fu_ready[i]) begin
                    slot_valid_q[i]  <= 1'b1;
                    slot_q[i].tag    <= bus.fu_tag[i*TAG_W +: TAG_W];
                    slot_q[i].result <= bus.fu_result[i*DATA_W +: DATA_W];
                    slot_q[i].br     <= bus.fu_br[i];
                    slot_q[i].br_idx <= bus.fu_br_idx[i*BR_IDX_W +: BR_IDX_W];
                    slot_q[i].take   <= bus.fu_take_branch[i];
                end else if (grant[i]) begin
                    slot_valid_q[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios followed by random traffic
// with random flushes and resets, checked against a queue-based reference model.
module tb_cdb_arbiter;
    localparam int unsigned NF = 4;
    localparam int unsigned NL = 2;
    localparam int unsigned TW = 6;
    localparam int unsigned DW = 64;
    localparam int unsigned BW = 3;

    typedef struct packed {
        logic [NL-1:0]         en;
        logic [NL-1:0][TW-1:0] tag;
        logic [NL-1:0][DW-1:0] res;
        logic                  brv;
        logic [BW-1:0]         bidx;
        logic                  take;
        logic [DW-1:0]         tgt;
        logic                  strict;
    } exp_t;

    typedef struct {
        bit            v;
        logic [TW-1:0] tag;
        logic [DW-1:0] res;
        bit            br;
        logic [BW-1:0] idx;
        bit            take;
    } mslot_t;

    logic clock;
    logic reset;
    cdb_arbiter_if #(.NUM_FU(NF), .NUM_LANES(NL), .TAG_W(TW), .DATA_W(DW), .BR_IDX_W(BW)) bus ();

    cdb_arbiter #(.NUM_FU(NF), .NUM_LANES(NL), .TAG_W(TW), .DATA_W(DW), .BR_IDX_W(BW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int     checks = 0;
    int     errors = 0;
    bit     mon_en = 0;
    exp_t   exp_q[$];
    mslot_t m [NF];
    int     m_rr = 0;
    logic [NF-1:0] m_hs;

    logic [NF-1:0] d_valid, d_br, d_take;
    logic [TW-1:0] d_tag [NF];
    logic [DW-1:0] d_res [NF];
    logic [BW-1:0] d_idx [NF];
    logic          d_flush, d_reset;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model resolves what the coming edge must broadcast.
    task automatic step();
        int   cand[$];
        int   picks[$];
        bit   br_used;
        bit   granted [NF];
        logic [NF-1:0] rdy;
        exp_t e;
        @(negedge clock);
        reset = d_reset;
        bus.flush = d_flush;
        for (int i = 0; i < int'(NF); i++) begin
            bus.fu_valid[i]                = d_valid[i];
            bus.fu_tag[i*TW +: TW]         = d_tag[i];
            bus.fu_result[i*DW +: DW]      = d_res[i];
            bus.fu_br[i]                   = d_br[i];
            bus.fu_br_idx[i*BW +: BW]      = d_idx[i];
            bus.fu_take_branch[i]          = d_take[i];
        end
        #1;
        br_used = 0;
        for (int k = 0; k < int'(NF); k++)
            if (m[(m_rr + k) % NF].v) cand.push_back((m_rr + k) % NF);
        foreach (cand[j]) begin
            if (picks.size() == int'(NL)) break;
            if (m[cand[j]].br) begin
                if (br_used) continue;
                br_used = 1;
            end
            picks.push_back(cand[j]);
        end
        for (int i = 0; i < int'(NF); i++) granted[i] = 0;
        foreach (picks[j]) granted[picks[j]] = 1;
        for (int i = 0; i < int'(NF); i++) rdy[i] = !d_flush && (!m[i].v || granted[i]);
        if (!d_reset) chk("fu_ready", 64'(bus.fu_ready), 64'(rdy));

        e = '0;
        m_hs = '0;
        if (d_reset) begin
            for (int i = 0; i < int'(NF); i++) m[i].v = 0;
            m_rr = 0;
            e.strict = 1'b1;
        end else if (d_flush) begin
            for (int i = 0; i < int'(NF); i++) m[i].v = 0;
        end else begin
            foreach (picks[j]) begin
                e.en[j]  = 1'b1;
                e.tag[j] = m[picks[j]].tag;
                e.res[j] = m[picks[j]].res;
                if (m[picks[j]].br) begin
                    e.brv  = 1'b1;
                    e.bidx = m[picks[j]].idx;
                    e.take = m[picks[j]].take;
                    e.tgt  = m[picks[j]].res;
                end
                m[picks[j]].v = 0;
            end
            if (picks.size() > 0) m_rr = (picks[picks.size()-1] + 1) % NF;
            m_hs = d_valid & rdy;
            for (int i = 0; i < int'(NF); i++) begin
                if (m_hs[i]) begin
                    m[i].v = 1; m[i].tag = d_tag[i]; m[i].res = d_res[i];
                    m[i].br = d_br[i]; m[i].idx = d_idx[i]; m[i].take = d_take[i];
                end
            end
        end
        exp_q.push_back(e);
        mon_en = 1;
    endtask

    // Monitor: every edge the bus presents is matched against the next expected entry.
    initial begin
        exp_t e;
        wait (mon_en);
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                chk("unexpected_cdb_en", 64'(bus.cdb_en), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("cdb_en", 64'(bus.cdb_en), 64'(e.en));
                chk("cdb_br_valid", 64'(bus.cdb_br_valid), 64'(e.brv));
                for (int l = 0; l < int'(NL); l++) begin
                    chk($sformatf("cdb_tag[%0d]", l), 64'(bus.cdb_tag[l*TW +: TW]), 64'(e.tag[l]));
                    if (e.en[l] || e.strict)
                        chk($sformatf("cdb_result[%0d]", l), bus.cdb_result[l*DW +: DW], e.res[l]);
                end
                if (e.brv || e.strict) begin
                    chk("cdb_br_idx", 64'(bus.cdb_br_idx), 64'(e.bidx));
                    chk("cdb_take_branch", 64'(bus.cdb_take_branch), 64'(e.take));
                    chk("cdb_br_target", bus.cdb_br_target, e.tgt);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle_drive();
        d_valid = '0; d_br = '0; d_take = '0; d_flush = 0; d_reset = 0;
        for (int i = 0; i < int'(NF); i++) begin
            d_tag[i] = '0; d_res[i] = '0; d_idx[i] = '0;
        end
    endtask

    task automatic do_reset();
        idle_drive();
        d_reset = 1;
        step();
        step();
        d_reset = 0;
    endtask

    task automatic idle(input int n);
        idle_drive();
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        bit            pend [NF];
        logic [TW-1:0] next_tag;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.fu_valid = '0; bus.fu_tag = '0; bus.fu_result = '0;
        bus.fu_br = '0; bus.fu_br_idx = '0; bus.fu_take_branch = '0;
        do_reset();

        // Single completion from FU2
        d_valid[2] = 1; d_tag[2] = TW'(6'h15); d_res[2] = 64'hABCD;
        step();
        idle(3);

        // All four FUs at once, no branches
        do_reset();
        for (int i = 0; i < int'(NF); i++) begin
            d_valid[i] = 1; d_tag[i] = TW'(i + 1); d_res[i] = DW'(100 + i);
        end
        step();
        idle(3);

        // Two branches compete; only one resolves per cycle
        do_reset();
        d_valid[0] = 1; d_tag[0] = TW'(7); d_res[0] = 64'h1000;
        d_br[0] = 1; d_idx[0] = BW'(5); d_take[0] = 1;
        d_valid[1] = 1; d_tag[1] = TW'(8); d_res[1] = 64'h2000;
        d_br[1] = 1; d_idx[1] = BW'(6); d_take[1] = 0;
        step();
        idle(4);

        // FUs 0 and 3 stream a new completion every cycle
        for (int c = 0; c < 8; c++) begin
            idle_drive();
            d_valid[0] = 1; d_tag[0] = TW'(16 + c); d_res[0] = DW'(c);
            d_valid[3] = 1; d_tag[3] = TW'(32 + c); d_res[3] = DW'(c + 50);
            step();
        end
        idle(3);

        // Flush while slots 1 and 2 hold work
        idle_drive();
        d_valid[1] = 1; d_tag[1] = TW'(6'h2A); d_res[1] = 64'h11;
        d_valid[2] = 1; d_tag[2] = TW'(6'h2B); d_res[2] = 64'h22;
        step();
        idle_drive();
        d_flush = 1;
        step();
        idle(3);

        // Random traffic with occasional flush and reset
        next_tag = '0;
        for (int i = 0; i < int'(NF); i++) pend[i] = 0;
        idle_drive();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < int'(NF); i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 65) begin
                    pend[i]   = 1;
                    next_tag  = next_tag + TW'(1);
                    d_tag[i]  = next_tag;
                    d_res[i]  = {$urandom, $urandom};
                    d_br[i]   = ($urandom_range(0, 2) == 0);
                    d_idx[i]  = BW'($urandom_range(0, 7));
                    d_take[i] = 1'($urandom_range(0, 1));
                end
                d_valid[i] = pend[i];
            end
            d_flush = ($urandom_range(0, 29) == 0);
            d_reset = ($urandom_range(0, 149) == 0);
            step();
            for (int i = 0; i < int'(NF); i++) if (m_hs[i]) pend[i] = 0;
        end
        idle(6);

        @(posedge clock);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
